// File: rtl/acc_mult_seq.sv
// Sequential shift-add multiplier with its own control FSM and Start/Pronto/Done handshake.
// Define ACC_SIGNED_EN for two's-complement operands (adds the SINAL sign-fix state).
module acc_mult_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     Multiplicando,
    input  logic [WIDTH-1:0]     Multiplicador,
    output logic                 Pronto,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Produto,
    output logic [2*WIDTH:0]     Saidas
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef ACC_SIGNED_EN
    typedef enum logic [1:0] {IDLE, CALC, SINAL, FIM} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALC, FIM} state_t;
`endif

    state_t                state, next_state;
    logic [CW-1:0]         cnt;
    logic [WIDTH-1:0]      m;
    logic [2*WIDTH:0]      acc;
    logic [WIDTH:0]        sum;
    logic [WIDTH-1:0]      op_m, op_q;

`ifdef ACC_SIGNED_EN
    logic                  neg;
    logic [2*WIDTH-1:0]    fixed_acc;

    // Magnitudes go through the unsigned core; -2^(W-1) negates to 2^(W-1), which still fits.
    assign op_m      = Multiplicando[WIDTH-1] ? -Multiplicando : Multiplicando;
    assign op_q      = Multiplicador[WIDTH-1] ? -Multiplicador : Multiplicador;
    assign fixed_acc = neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
`else
    assign op_m = Multiplicando;
    assign op_q = Multiplicador;
`endif

    assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m};
    assign Pronto = (state == IDLE);
    assign Done   = (state == FIM);
    assign Saidas = acc;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    next_state = CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
`ifdef ACC_SIGNED_EN
                    next_state = SINAL;
`else
                    next_state = FIM;
`endif
                end
            end
`ifdef ACC_SIGNED_EN
            SINAL:   next_state = FIM;
`endif
            FIM:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // CALC runs exactly WIDTH add/shift steps, then spends one edge leaving with cnt at zero.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            acc     <= '0;
            m       <= '0;
            cnt     <= '0;
            Produto <= '0;
`ifdef ACC_SIGNED_EN
            neg     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        m   <= op_m;
                        acc <= {{(WIDTH+1){1'b0}}, op_q};
                        cnt <= CW'(WIDTH);
`ifdef ACC_SIGNED_EN
                        neg <= Multiplicando[WIDTH-1] ^ Multiplicador[WIDTH-1];
`endif
                    end
                end
                CALC: begin
                    if (cnt != '0) begin
                        if (acc[0]) begin
                            acc <= {1'b0, sum, acc[WIDTH-1:1]};
                        end else begin
                            acc <= acc >> 1;
                        end
                        cnt <= cnt - CW'(1);
                    end
`ifndef ACC_SIGNED_EN
                    else begin
                        Produto <= acc[2*WIDTH-1:0];
                    end
`endif
                end
`ifdef ACC_SIGNED_EN
                SINAL: begin
                    acc[2*WIDTH-1:0] <= fixed_acc;
                    Produto          <= fixed_acc;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
